pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 112 +++++++++++
 tb/tb_pipe_chain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// Elastic register chain with collapsing bubbles, per-stage flush and hazard match vectors.
// Optional input back-pressure counter enabled by defining PIPE_CHAIN_STALL_CNT_EN.
module pipe_chain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wb_en,
    input  logic [DEPTH-1:0]  flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_wb_en,
    input  logic              out_ready,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic [DEPTH-1:0]  hit_a,
    output logic [DEPTH-1:0]  hit_b,
    output logic [3:0]        occupancy,
    output logic [31:0]       stall_cnt
);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DEPTH-1:0]  wb_en_q;
    logic [DEPTH-1:0]  adv;
    logic              load_0;

    // A stage advances when it is valid and the stage ahead is empty or itself advancing.
    always_comb begin
        logic [DEPTH-1:0] a;
        a = '0;
        a[DEPTH-1] = valid_q[DEPTH-1] & out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            a[k] = valid_q[k] & (~valid_q[k+1] | a[k+1]);
        end
        adv = a;
    end

    assign in_ready = ~valid_q[0] | adv[0];
    assign load_0   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            wb_en_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                dest_q[k] <= '0;
            end
        end else begin
            if (load_0) begin
                valid_q[0] <= 1'b1;
                data_q[0]  <= in_data;
                dest_q[0]  <= in_dest;
                wb_en_q[0] <= in_wb_en;
            end else if (adv[0]) begin
                valid_q[0] <= 1'b0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= data_q[k-1];
                    dest_q[k]  <= dest_q[k-1];
                    wb_en_q[k] <= wb_en_q[k-1];
                end else if (adv[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            // NOTE: the last non-blocking assignment to a bit wins, so flush overrides any capture above.
            for (int k = 0; k < DEPTH; k++) begin
                if (flush[k]) valid_q[k] <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_dest  = dest_q[DEPTH-1];
    assign out_wb_en = wb_en_q[DEPTH-1];

    always_comb begin
        hit_a     = '0;
        hit_b     = '0;
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_a[k]  = valid_q[k] & wb_en_q[k] & (dest_q[k] == src_a) & (src_a != '0);
            hit_b[k]  = valid_q[k] & wb_en_q[k] & (dest_q[k] == src_b) & (src_b != '0);
            occupancy = occupancy + 4'(valid_q[k]);
        end
    end

`ifdef PIPE_CHAIN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus random traffic against a slot-level model.
module tb_pipe_chain;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_dest;
    logic              in_wb_en;
    logic [DEPTH-1:0]  flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_dest;
    logic              out_wb_en;
    logic              out_ready;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [DEPTH-1:0]  hit_a;
    logic [DEPTH-1:0]  hit_b;
    logic [3:0]        occupancy;
    logic [31:0]       stall_cnt;

    pipe_chain #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_wb_en(in_wb_en), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
        .out_wb_en(out_wb_en), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b), .hit_a(hit_a), .hit_b(hit_b),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                v;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        bit                w;
    } slot_t;

    slot_t       m [DEPTH];
    logic [31:0] m_stall;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_popped = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < DEPTH; k++) m[k] = '{v: 1'b0, d: '0, a: '0, w: 1'b0};
        m_stall = '0;
    endtask

    // An item moves iff the sink takes data or any slot downstream of it is empty.
    function automatic bit m_moves(int k);
        if (!m[k].v) return 1'b0;
        if (out_ready) return 1'b1;
        for (int j = k + 1; j < DEPTH; j++) if (!m[j].v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model();
        logic [DEPTH-1:0] ea, eb;
        int occ;
        ea = '0; eb = '0; occ = 0;
        for (int k = 0; k < DEPTH; k++) begin
            ea[k] = m[k].v && m[k].w && (m[k].a == src_a) && (src_a != 0);
            eb[k] = m[k].v && m[k].w && (m[k].a == src_b) && (src_b != 0);
            occ += int'(m[k].v);
        end
        check("in_ready", in_ready, !m[0].v || m_moves(0));
        check("out_valid", out_valid, m[DEPTH-1].v);
        if (m[DEPTH-1].v) begin
            check("out_data", out_data, m[DEPTH-1].d);
            check("out_dest", out_dest, m[DEPTH-1].a);
            check("out_wb_en", out_wb_en, m[DEPTH-1].w);
        end
        check("hit_a", hit_a, ea);
        check("hit_b", hit_b, eb);
        check("occupancy", occupancy, occ);
`ifdef PIPE_CHAIN_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`else
        check("stall_cnt", stall_cnt, 0);
`endif
        if (out_valid && out_ready) n_popped++;
    endtask

    task automatic model_step();
        slot_t nm [DEPTH];
        bit mv [DEPTH];
        bit rdy;
        for (int k = 0; k < DEPTH; k++) mv[k] = m_moves(k);
        rdy = !m[0].v || mv[0];
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (mv[k-1])   nm[k] = m[k-1];
            else begin
                nm[k] = m[k];
                if (mv[k]) nm[k].v = 1'b0;
            end
        end
        if (in_valid && rdy) nm[0] = '{v: 1'b1, d: in_data, a: in_dest, w: in_wb_en};
        else begin
            nm[0] = m[0];
            if (mv[0]) nm[0].v = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) if (flush[k]) nm[k].v = 1'b0;
        if (in_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        for (int k = 0; k < DEPTH; k++) m[k] = nm[k];
    endtask

    // Inputs are set at the falling edge; the tick checks then lets one rising edge pass.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, input bit w);
        in_valid = v; in_data = d; in_dest = a; in_wb_en = w;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; out_ready = 1'b1; flush = '0; src_a = '0; src_b = '0;
        drive(1'b0, '0, '0, 1'b0);
        m_reset();
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Three back-to-back pushes: output appears DEPTH-1 edges after acceptance.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA1 + i, 5'(i + 1), 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        #1;
        check("lat_occ_peak", occupancy, 3);
        check("lat_not_yet", out_valid, 0);
        tick();
        check("lat_first", out_data, 32'hA1);
        check("lat_first_v", out_valid, 1);
        tick();
        check("lat_second", out_data, 32'hA2);
        tick();
        check("lat_third", out_data, 32'hA3);
        tick();
        check("lat_drained", out_valid, 0);

        // Fill then stall with input pending for five cycles.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + i, 5'(i + 1), 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1FF, 5'd9, 1'b0);
            tick();
        end
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_occ", occupancy, 4);
`ifdef PIPE_CHAIN_STALL_CNT_EN
        check("stall_count", stall_cnt, 5);
`else
        check("stall_count", stall_cnt, 0);
`endif
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        n_popped = 0;
        repeat (6) tick();
        check("stall_drain_cnt", n_popped, 4);

        // Hazard vectors: stage1 dest7/wb1, stage2 dest0/wb1, stage3 non-writing.
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h31, 5'd3, 1'b0); tick();
        drive(1'b1, 32'h32, 5'd0, 1'b1); tick();
        drive(1'b1, 32'h33, 5'd7, 1'b1); tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) tick();
        src_a = 5'd7; src_b = 5'd0;
        #1;
        check("haz_hit_a", hit_a, 4'b0010);
        check("haz_hit_b", hit_b, 4'b0000);
        tick();
        src_a = '0;

        // Flush stage 1 while its incoming item moves up and a new item enters stage 0.
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h51, 5'd1, 1'b1); tick();
        drive(1'b1, 32'h52, 5'd2, 1'b1); flush = 4'b0010; tick();
        flush = '0;
        drive(1'b0, '0, '0, 1'b0);
        #1;
        check("flush_occ", occupancy, 1);
        repeat (4) tick();

        // Reset mid-stream with three valid stages.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h70 + i, 5'd4, 1'b1);
            tick();
        end
        src_a = 5'd4;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_stall", stall_cnt, 0);
        check("mid_rst_hit_a", hit_a, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h99, 5'd5, 1'b0); tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) tick();
        #1;
        check("post_rst_not_yet", out_valid, 0);
        tick();
        check("post_rst_lat", out_data, 32'h99);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom(), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            out_ready = $urandom_range(0, 9) < 6;
            flush     = ($urandom_range(0, 5) == 0) ? DEPTH'($urandom_range(0, 15)) : '0;
            src_a     = 5'($urandom_range(0, 7));
            src_b     = 5'($urandom_range(0, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
